// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle RV32I control unit.
// Holds the instruction register, sequences FETCH/DECODE/EXEC/MEM/BTGT/TRAP and
// decodes ALU control, operand selects, immediates and datapath strobes.
module rv_ctrl_fsm #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [2:0]  funct3,
    output logic [3:0]  ALUCtrl,
    output logic [1:0]  in1_sel,
    output logic        in2_sel,
    output logic [31:0] imm,
    input  logic        branch,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_src,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_BTGT,
        S_TRAP
    } state_t;

    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_taken;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_illegal;
    logic        w_rf_wr;

    assign w_opc    = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign funct3   = w_f3;
    assign rs1_addr = r_ir[19:15];
    assign rs2_addr = r_ir[24:20];
    assign rd_addr  = r_ir[11:7];

    // Legality check of the held instruction, consumed in DECODE
    always_comb begin
        w_illegal = 1'b0;
        case (w_opc)
            OPC_OP:     w_illegal = !((w_f7 == 7'd0) ||
                                      ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            OPC_OPIMM: begin
                if (w_f3 == 3'b001)
                    w_illegal = (w_f7 != 7'd0);
                else if (w_f3 == 3'b101)
                    w_illegal = !((w_f7 == 7'd0) || (w_f7 == F7_ALT));
            end
            OPC_BRANCH: w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            OPC_LOAD:   w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            OPC_STORE:  w_illegal = (w_f3 > 3'b010);
            OPC_JALR:   w_illegal = (w_f3 != 3'b000);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: w_illegal = 1'b0;
            default:    w_illegal = 1'b1;
        endcase
    end

    // Immediate formatting by instruction format; shifts expose only shamt
    always_comb begin
        imm = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_opc)
            OPC_OPIMM: begin
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101))
                    imm = {27'd0, r_ir[24:20]};
            end
            OPC_STORE:  imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            OPC_BRANCH: imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {r_ir[31:12], 12'd0};
            OPC_JAL:    imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            default:    ;
        endcase
    end

    // Output decode from state and IR; strobes are masked during reset
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ALUCtrl  = 4'b0000;
        in1_sel  = 2'b00;
        in2_sel  = 1'b1;
        wb_sel   = 2'b00;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        illegal  = 1'b0;
        w_rf_wr  = 1'b0;

        // ALU selects by class; held unchanged through MEM
        case (w_opc)
            OPC_OP: begin
                ALUCtrl = {r_ir[30], w_f3};
                in2_sel = 1'b0;
            end
            OPC_OPIMM:  ALUCtrl = {(w_f3 == 3'b101) & r_ir[30], w_f3};
            OPC_LUI:    in1_sel = 2'b10;
            OPC_AUIPC:  in1_sel = 2'b01;
            OPC_JAL:    in1_sel = 2'b01;
            OPC_BRANCH: begin
                ALUCtrl = {1'b1, w_f3};
                in2_sel = 1'b0;
            end
            default: ;
        endcase

        case (w_opc)
            OPC_LOAD:           wb_sel = 2'b01;
            OPC_JAL, OPC_JALR:  wb_sel = 2'b10;
            default:            ;
        endcase

        case (r_state)
            S_FETCH: mem_req = 1'b1;
            S_DECODE: ;
            S_EXEC: begin
                case (w_opc)
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                        w_rf_wr = 1'b1;
                        pc_we   = 1'b1;
                    end
                    OPC_JAL, OPC_JALR: begin
                        w_rf_wr = 1'b1;
                        pc_we   = 1'b1;
                        pc_src  = 1'b1;
                    end
                    OPC_FENCE: pc_we = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (w_opc == OPC_STORE);
                if (mem_ready) begin
                    w_rf_wr = (w_opc == OPC_LOAD);
                    pc_we   = 1'b1;
                end
            end
            S_BTGT: begin
                in1_sel = 2'b01;
                in2_sel = 1'b1;
                ALUCtrl = 4'b0000;
                pc_we   = 1'b1;
                pc_src  = r_taken;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase

        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            w_rf_wr = 1'b0;
            pc_we   = 1'b0;
            illegal = 1'b0;
        end
    end

    assign rf_we = w_rf_wr & (rd_addr != 5'd0);

    // State, instruction register and branch-taken flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= NOP_INSTR;
            r_taken <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= w_illegal ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    case (w_opc)
                        OPC_BRANCH: begin
                            r_taken <= branch;
                            r_state <= S_BTGT;
                        end
                        OPC_LOAD, OPC_STORE: r_state <= S_MEM;
                        default:             r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        r_state <= S_FETCH;
                end
                S_BTGT:  r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
